// File: rtl/data_sram_resp_if.sv
// Data-side SRAM-like request/response bus between the MEM stage (master)
// and a memory responder (slave).
interface data_sram_resp_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_wstrb,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_wstrb,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// Responder for the data-side SRAM-like interface. Stores are applied and
// loads are sampled into a word-addressed memory at accept time; each
// accepted request is answered in order with a single data_ok pulse exactly
// LATENCY cycles later. At most MAX_OUTSTANDING requests may be in flight.
// Memory contents survive reset; only in-flight responses are dropped.
module data_sram_resp #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic             clk,
  input logic             reset,
  data_sram_resp_if.slave bus
);

  localparam int unsigned PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem       [DEPTH];

  logic              ent_valid [MAX_OUTSTANDING];
  logic              ent_load  [MAX_OUTSTANDING];
  logic [31:0]       ent_data  [MAX_OUTSTANDING];
  logic [3:0]        ent_rem   [MAX_OUTSTANDING];

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [2:0]        count;
  logic              reset_q;

  logic              accept;
  logic              data_ok;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rword;
  logic              unused_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign widx  = bus.data_sram_addr[ADDR_W+1:2];
  assign rword = mem[widx];

  // Size is informational and the address bits outside the word index alias.
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr};

  // reset_q holds addr_ok low for the first cycle after reset drops.
  assign bus.data_sram_addr_ok = !reset && !reset_q && (count < 3'(MAX_OUTSTANDING));
  assign accept                = bus.data_sram_req && bus.data_sram_addr_ok;

  assign data_ok               = !reset && ent_valid[head] && (ent_rem[head] == 4'd0);
  assign bus.data_sram_data_ok = data_ok;
  assign bus.data_sram_rdata   = (data_ok && ent_load[head]) ? ent_data[head] : '0;

  // Byte-lane store into the word array on an accepted store (not reset).
  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.data_sram_wstrb[i]) begin
          mem[widx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Tracking FIFO: age entries, retire the head on data_ok, enqueue on accept.
  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        ent_valid[i] <= 1'b0;
        ent_load[i]  <= 1'b0;
        ent_data[i]  <= '0;
        ent_rem[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        if (ent_valid[i] && (ent_rem[i] != 4'd0)) begin
          ent_rem[i] <= ent_rem[i] - 4'd1;
        end
      end

      if (data_ok) begin
        ent_valid[head] <= 1'b0;
        head            <= next_ptr(head);
      end

      // The tail slot is always free when accept is possible (count < MAX).
      if (accept) begin
        ent_valid[tail] <= 1'b1;
        ent_load[tail]  <= !bus.data_sram_wr;
        ent_data[tail]  <= bus.data_sram_wr ? '0 : rword;
        ent_rem[tail]   <= 4'(LATENCY - 1);
        tail            <= next_ptr(tail);
      end

      case ({accept, data_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: two instances (LATENCY=2/MAX=2 and
// LATENCY=1/MAX=1). A reference memory and per-instance response queue
// predict addr_ok, data_ok and rdata every cycle.
module tb_data_sram_resp;

  localparam int unsigned LAT0 = 2;
  localparam int unsigned MAX0 = 2;
  localparam int unsigned LAT1 = 1;
  localparam int unsigned MAX1 = 1;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  data_sram_resp_if if0 ();
  data_sram_resp_if if1 ();

  data_sram_resp #(.ADDR_W(10), .LATENCY(LAT0), .MAX_OUTSTANDING(MAX0)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (if0)
  );

  data_sram_resp #(.ADDR_W(10), .LATENCY(LAT1), .MAX_OUTSTANDING(MAX1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] cyc;

  ent_t        sb       [2][$];
  logic [31:0] ref_mem  [2][1024];

  logic        in_rst   [2];
  logic        in_req   [2];
  logic        in_wr    [2];
  logic [3:0]  in_stb   [2];
  logic [31:0] in_addr  [2];
  logic [31:0] in_wdata [2];
  logic        rst_prev [2];
  logic        last_acc [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic apply();
    rst0                 = in_rst[0];
    if0.data_sram_req    = in_req[0];
    if0.data_sram_wr     = in_wr[0];
    if0.data_sram_size   = 2'd2;
    if0.data_sram_wstrb  = in_stb[0];
    if0.data_sram_addr   = in_addr[0];
    if0.data_sram_wdata  = in_wdata[0];
    rst1                 = in_rst[1];
    if1.data_sram_req    = in_req[1];
    if1.data_sram_wr     = in_wr[1];
    if1.data_sram_size   = 2'd2;
    if1.data_sram_wstrb  = in_stb[1];
    if1.data_sram_addr   = in_addr[1];
    if1.data_sram_wdata  = in_wdata[1];
  endtask

  // Compare one instance's outputs for the current cycle, then advance its model.
  task automatic eval(input int k);
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        exp_aok;
    logic        exp_dok;
    logic [31:0] exp_rd;
    logic [9:0]  widx;
    int          lat;
    int          maxo;
    ent_t        e;
    lat  = (k == 0) ? int'(LAT0) : int'(LAT1);
    maxo = (k == 0) ? int'(MAX0) : int'(MAX1);
    if (k == 0) begin
      aok = if0.data_sram_addr_ok;
      dok = if0.data_sram_data_ok;
      rd  = if0.data_sram_rdata;
    end else begin
      aok = if1.data_sram_addr_ok;
      dok = if1.data_sram_data_ok;
      rd  = if1.data_sram_rdata;
    end
    exp_aok = !in_rst[k] && !rst_prev[k] && (sb[k].size() < maxo);
    exp_dok = !in_rst[k] && (sb[k].size() != 0) && (sb[k][0].due == cyc);
    exp_rd  = exp_dok ? sb[k][0].data : 32'h0;
    chk($sformatf("dut%0d_addr_ok", k), {31'h0, aok}, {31'h0, exp_aok});
    chk($sformatf("dut%0d_data_ok", k), {31'h0, dok}, {31'h0, exp_dok});
    if (exp_dok || in_rst[k] || rst_prev[k]) chk($sformatf("dut%0d_rdata", k), rd, exp_rd);
    if (exp_dok) void'(sb[k].pop_front());
    if (in_rst[k]) sb[k].delete();
    last_acc[k] = in_req[k] && exp_aok;
    if (last_acc[k]) begin
      widx = in_addr[k][11:2];
      if (in_wr[k]) begin
        for (int i = 0; i < 4; i++) begin
          if (in_stb[k][i]) ref_mem[k][widx][8*i +: 8] = in_wdata[k][8*i +: 8];
        end
        e.data = 32'h0;
      end else begin
        e.data = ref_mem[k][widx];
      end
      e.due = cyc + 32'(lat);
      sb[k].push_back(e);
    end
    rst_prev[k] = in_rst[k];
  endtask

  task automatic tick();
    apply();
    @(negedge clk);
    eval(0);
    eval(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input int k, input logic w, input logic [3:0] stb,
                       input logic [31:0] a, input logic [31:0] d);
    int tries;
    tries       = 0;
    in_req[k]   = 1'b1;
    in_wr[k]    = w;
    in_stb[k]   = stb;
    in_addr[k]  = a;
    in_wdata[k] = d;
    do begin
      tick();
      tries++;
    end while (!last_acc[k] && tries < 8);
    if (!last_acc[k]) chk($sformatf("dut%0d_accept_timeout", k), {31'h0, last_acc[k]}, 32'h1);
    in_req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      in_rst[k]   = 1'b1;
      in_req[k]   = 1'b0;
      in_wr[k]    = 1'b0;
      in_stb[k]   = 4'h0;
      in_addr[k]  = 32'h0;
      in_wdata[k] = 32'h0;
      rst_prev[k] = 1'b1;
      last_acc[k] = 1'b0;
    end
    apply();
    @(posedge clk);
    #1;
    idle(2);
    in_rst[0] = 1'b0;
    in_rst[1] = 1'b0;
    idle(2);

    // Store then back-to-back load of the same word.
    issue(0, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    idle(3);

    // Partial-lane store, then an all-lanes-disabled store.
    issue(0, 1'b1, 4'b0100, 32'h0000_0010, 32'h00AB_0000);
    issue(0, 1'b0, 4'h0,    32'h0000_0010, 32'h0);
    issue(0, 1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF);
    issue(0, 1'b0, 4'h0,    32'h0000_0010, 32'h0);
    idle(3);

    // Upper address bits alias onto the same word.
    issue(0, 1'b1, 4'hF, 32'h1000_0010, 32'hCAFE_F00D);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    idle(3);

    // Held request stream against a full tracking FIFO.
    issue(0, 1'b1, 4'hF, 32'h0000_0020, 32'hA5A5_0001);
    idle(3);
    in_req[0]  = 1'b1;
    in_wr[0]   = 1'b0;
    in_stb[0]  = 4'h0;
    in_addr[0] = 32'h0000_0020;
    idle(7);
    in_req[0]  = 1'b0;
    idle(4);

    // Reset while a load is in flight; memory must survive.
    issue(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    in_rst[0] = 1'b1;
    tick();
    in_rst[0] = 1'b0;
    idle(2);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    idle(3);

    // Single-entry, single-cycle instance with alternating store/load.
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b1, 4'hF, 32'h40 + 32'(4 * i), 32'hD00D_0000 + 32'(i));
      issue(1, 1'b0, 4'h0, 32'h40 + 32'(4 * i), 32'h0);
    end
    idle(3);

    // Mixed traffic with random strobes over a prewritten window.
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 4'hF, 32'h80 + 32'(4 * i), $urandom);
    for (int i = 0; i < 24; i++) begin
      issue(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            32'h80 + 32'(4 * $urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
